packet_rr_arbiter: RTL and testbench
====================================

Name: packet_rr_arbiter

Overview:
- Shares one sample/message output stream between N_STREAMS independent packetised input streams, such as several qa_contents outputs or a sample path plus a control path.
- Each input is buffered in its own FIFO. A round-robin scheduler grants the output to one stream at a time for a whole packet, so packets are never interleaved.
- Sits upstream of the stream combiner and output formatter.
- Uses only nd-style valid strobes; there is no backpressure on inputs or output.

Parameters:
- N_STREAMS, 2, number of input streams (2..8).
- WDTH, 32, word width.
- LOG_BUF_LEN, 4, log2 of the per-stream FIFO depth; depth is 16 words.
- LEN_WIDTH, 8, width of the header length field; must be less than WDTH.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_STREAMS*WDTH  concatenated input words; stream i occupies bits [i*WDTH +: WDTH].
- in_nd  input  N_STREAMS  per-stream new-data strobe.
- out_data  output  WDTH  output word.
- out_nd  output  1  output new-data strobe.
- out_stream  output  clog2(N_STREAMS), min 1  index of the stream driving the current out_data.
- error  output  1  sticky error flag.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset state:
  - out_data=0, out_nd=0, out_stream=0, error=0.
  - All FIFOs empty; state=IDLE; rr pointer=0; payload counter=0.
- Packet format:
  - Header word has bit WDTH-1 = 1.
  - Header bits [LEN_WIDTH-1:0] give L, the number of payload words that follow (0..2^LEN_WIDTH-1).
  - Payload words are unconstrained.
  - Headers are forwarded unchanged.
- FIFO write:
  - When in_nd[i]=1 and FIFO i is not full, the word is written.
  - When FIFO i is full, the word is dropped and error is set. This holds even if a pop of FIFO i happens in the same cycle.
  - A word written at edge t is poppable from cycle t+1 onward. An empty FIFO cannot bypass to its read side.
- At most one pop per cycle across all FIFOs.
- out_data, out_nd and out_stream are registered: a word popped in cycle c appears with out_nd=1 in cycle c+1. In all other cycles out_nd=0 and out_data holds its last value.
- State IDLE:
  - Search streams starting at rr pointer and wrapping modulo N_STREAMS. Select the first stream with a non-empty FIFO.
  - If the head word is a header: pop it, emit it, set counter=L and grant=selected stream.
    - L>0: go to SEND.
    - L=0: stay IDLE.
    - In both cases rr pointer = selected+1 (mod N_STREAMS).
  - If the head word is not a header: pop and discard it, set error, no output, rr pointer = selected+1, stay IDLE.
  - If no FIFO is non-empty: stay IDLE.
- State SEND:
  - If FIFO[grant] is non-empty: pop, emit, decrement counter. When the counter reaches 0 after this pop, go to IDLE.
  - If FIFO[grant] is empty: stall with no output and remain in SEND. There is no timeout.
  - Other streams keep filling their FIFOs but are not served.
- Back-to-back packets are contiguous: the last payload pop is in cycle k, the next header pop is in cycle k+1, so outputs run with no bubble.
- Minimum latency through an idle arbiter with an empty FIFO is 2 cycles from the in_nd edge to out_nd.
- error is sticky; only rst_n clears it.
- Reset asserted mid-packet: everything returns to reset state immediately and all buffered words are lost.

Test Plan:
- Single packet: stream 0 receives header 0x80000003 then payloads 0xA, 0xB, 0xC on consecutive cycles. Out must show 0x80000003, 0xA, 0xB, 0xC on 4 consecutive cycles, with the header appearing 2 cycles after its in_nd, out_stream=0 and error=0.
- Round-robin: streams 0 and 1 each hold two length-1 packets before the arbiter starts. Output order must be s0, s1, s0, s1 (8 contiguous words), with out_stream toggling at each header.
- Stall plus no interleave: stream 0 sends header L=2 and one payload, then pauses 5 cycles, while stream 1 sends a full packet. Stream 1 words must not appear until stream 0's second payload is output; out_nd must be low during the stall.
- Zero-length: stream 1 sends 0x80000000 followed immediately by header L=1 and payload 0x5. Out must show 0x80000000, 0x80000001, 0x5 on consecutive cycles.
- Errors: a non-header word 0x00000007 as the first word on stream 0 must be discarded with error=1 and no out_nd. Separately, 17 words written to an unserved stream (stream 1 stalled behind stream 0 in SEND) must leave exactly 16 stored and set error.
- Reset mid-packet: pulse rst_n low during SEND. Outputs must be zero immediately, and after release a new packet on stream 1 must be output normally with error=0.

Source files
------------

// File: rtl/packet_rr_arbiter.sv
// packet_rr_arbiter: per-stream FIFOs feeding one output, granted round-robin a whole packet at a time.
module packet_rr_arbiter #(
    parameter int N_STREAMS   = 2,
    parameter int WDTH        = 32,
    parameter int LOG_BUF_LEN = 4,
    parameter int LEN_WIDTH   = 8,
    localparam int SW = N_STREAMS > 1 ? $clog2(N_STREAMS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_STREAMS*WDTH-1:0] in_data,
    input  logic [N_STREAMS-1:0]      in_nd,
    output logic [WDTH-1:0]           out_data,
    output logic                      out_nd,
    output logic [SW-1:0]             out_stream,
    output logic                      error
);
    localparam int DEPTH = 1 << LOG_BUF_LEN;

    typedef enum logic {IDLE, SEND} state_t;

    logic [WDTH-1:0]        mem_q  [N_STREAMS][DEPTH];
    logic [LOG_BUF_LEN-1:0] wptr_q [N_STREAMS];
    logic [LOG_BUF_LEN-1:0] rptr_q [N_STREAMS];
    logic [LOG_BUF_LEN:0]   cnt_q  [N_STREAMS];
    state_t                 state_q;
    logic [SW-1:0]          rr_q, grant_q, out_stream_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [WDTH-1:0]        out_data_q;
    logic                   out_nd_q, error_q;

    logic [SW-1:0]   sel_d;
    logic [SW:0]     idx;
    logic            pop_d;
    logic [WDTH-1:0] head_d;

    assign out_data   = out_data_q;
    assign out_nd     = out_nd_q;
    assign out_stream = out_stream_q;
    assign error      = error_q;

    // IDLE scans from rr_q for the first non-empty FIFO; SEND is locked to the granted stream.
    always_comb begin
        sel_d = rr_q;
        pop_d = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_STREAMS; k++) begin
            idx = {1'b0, rr_q} + (SW+1)'(k);
            idx = idx >= (SW+1)'(N_STREAMS) ? idx - (SW+1)'(N_STREAMS) : idx;
            if (!pop_d && cnt_q[idx[SW-1:0]] != '0) begin
                pop_d = 1'b1;
                sel_d = idx[SW-1:0];
            end
        end
        if (state_q == SEND) begin
            sel_d = grant_q;
            pop_d = cnt_q[grant_q] != '0;
        end
        head_d = mem_q[sel_d][rptr_q[sel_d]];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_STREAMS; i++)
            if (in_nd[i] && !cnt_q[i][LOG_BUF_LEN])
                mem_q[i][wptr_q[i]] <= in_data[i*WDTH +: WDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STREAMS; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            state_q      <= IDLE;
            rr_q         <= '0;
            grant_q      <= '0;
            len_q        <= '0;
            out_data_q   <= '0;
            out_nd_q     <= 1'b0;
            out_stream_q <= '0;
            error_q      <= 1'b0;
        end else begin
            out_nd_q <= 1'b0;
            for (int i = 0; i < N_STREAMS; i++) begin
                // A full FIFO drops the word even if it is being popped this cycle.
                if (in_nd[i] && !cnt_q[i][LOG_BUF_LEN])
                    wptr_q[i] <= wptr_q[i] + 1'b1;
                if (in_nd[i] && cnt_q[i][LOG_BUF_LEN])
                    error_q <= 1'b1;
                cnt_q[i] <= cnt_q[i]
                          + (LOG_BUF_LEN+1)'(in_nd[i] && !cnt_q[i][LOG_BUF_LEN])
                          - (LOG_BUF_LEN+1)'(pop_d && sel_d == SW'(i));
            end
            if (pop_d) begin
                rptr_q[sel_d] <= rptr_q[sel_d] + 1'b1;
                if (state_q == IDLE) begin
                    rr_q <= sel_d == SW'(N_STREAMS-1) ? '0 : sel_d + 1'b1;
                    if (head_d[WDTH-1]) begin
                        out_data_q   <= head_d;
                        out_nd_q     <= 1'b1;
                        out_stream_q <= sel_d;
                        grant_q      <= sel_d;
                        len_q        <= head_d[LEN_WIDTH-1:0];
                        state_q      <= head_d[LEN_WIDTH-1:0] != '0 ? SEND : IDLE;
                    end else begin
                        error_q <= 1'b1;
                    end
                end else begin
                    out_data_q   <= head_d;
                    out_nd_q     <= 1'b1;
                    out_stream_q <= sel_d;
                    len_q        <= len_q - 1'b1;
                    state_q      <= len_q == LEN_WIDTH'(1) ? IDLE : SEND;
                end
            end
        end
    end
endmodule

// File: tb/tb_packet_rr_arbiter.sv
// tb_packet_rr_arbiter: directed scenarios with a scoreboard of expected output words.
module tb_packet_rr_arbiter;
    localparam int N = 2;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_nd = '0;
    logic [W-1:0]   out_data;
    logic           out_nd;
    logic           out_stream;
    logic           error;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int d;
    logic [W:0] exp_q[$];
    int out_cyc[$];

    packet_rr_arbiter #(.N_STREAMS(N), .WDTH(W), .LOG_BUF_LEN(4), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd),
        .out_data(out_data), .out_nd(out_nd), .out_stream(out_stream), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int oc(input int i);
        return i < out_cyc.size() ? out_cyc[i] : -1000;
    endfunction

    // Advance one cycle and score any output word against the expectation queue.
    task automatic tick();
        logic [W:0] e;
        @(posedge clk);
        cyc++;
        #1;
        if (out_nd) begin
            out_cyc.push_back(cyc);
            checks++;
            assert (exp_q.size() != 0) passes++;
            else $error("FAIL unexpected_out: got %h expected no output", out_data);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e[W-1:0]);
                chk("out_stream", {31'b0, out_stream}, {31'b0, e[W]});
            end
        end
    endtask

    task automatic send(input logic [N-1:0] nd, input logic [W-1:0] d0, input logic [W-1:0] d1);
        in_nd = nd;
        in_data = {d1, d0};
        tick();
        in_nd = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic exp_w(input int s, input logic [W-1:0] v);
        exp_q.push_back({s[0], v});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_nd = '0;
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        out_cyc.delete();
    endtask

    task automatic drained(input string tag);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        tick();
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_nd", {31'b0, out_nd}, 32'h0);
        chk("rst_out_stream", {31'b0, out_stream}, 32'h0);
        chk("rst_error", {31'b0, error}, 32'h0);
        rst_n = 1'b1;
        tick();

        // single packet on stream 0
        exp_w(0, 32'h8000_0003); exp_w(0, 32'hA); exp_w(0, 32'hB); exp_w(0, 32'hC);
        d = cyc;
        send(2'b01, 32'h8000_0003, 0);
        send(2'b01, 32'hA, 0);
        send(2'b01, 32'hB, 0);
        send(2'b01, 32'hC, 0);
        idle(6);
        drained("t1_drain");
        chk("t1_header_latency", oc(0), d + 2);
        chk("t1_last_cycle", oc(3), d + 5);
        chk("t1_error", {31'b0, error}, 32'h0);

        // round-robin across two buffered streams
        do_reset();
        exp_w(0, 32'h8000_0001); exp_w(0, 32'h1001);
        exp_w(1, 32'h8000_0001); exp_w(1, 32'h2001);
        exp_w(0, 32'h8000_0001); exp_w(0, 32'h1002);
        exp_w(1, 32'h8000_0001); exp_w(1, 32'h2002);
        send(2'b11, 32'h8000_0001, 32'h8000_0001);
        send(2'b11, 32'h1001, 32'h2001);
        send(2'b11, 32'h8000_0001, 32'h8000_0001);
        send(2'b11, 32'h1002, 32'h2002);
        idle(10);
        drained("t2_drain");
        chk("t2_contiguous", oc(7) - oc(0), 7);

        // stall in SEND must not let stream 1 interleave
        do_reset();
        exp_w(0, 32'h8000_0002); exp_w(0, 32'h11); exp_w(0, 32'h12);
        exp_w(1, 32'h8000_0001); exp_w(1, 32'h21);
        send(2'b01, 32'h8000_0002, 0);
        send(2'b11, 32'h11, 32'h8000_0001);
        send(2'b10, 0, 32'h21);
        idle(4);
        send(2'b01, 32'h12, 0);
        idle(8);
        drained("t3_drain");
        chk("t3_stall_gap", oc(2) - oc(1), 6);
        chk("t3_s1_follows", oc(3) - oc(2), 1);

        // zero-length packet followed by a normal one
        do_reset();
        exp_w(1, 32'h8000_0000); exp_w(1, 32'h8000_0001); exp_w(1, 32'h5);
        send(2'b10, 0, 32'h8000_0000);
        send(2'b10, 0, 32'h8000_0001);
        send(2'b10, 0, 32'h5);
        idle(5);
        drained("t4_drain");
        chk("t4_contiguous", oc(2) - oc(0), 2);

        // non-header at packet start is discarded
        do_reset();
        send(2'b01, 32'h7, 0);
        idle(4);
        chk("t5_bad_header_error", {31'b0, error}, 32'h1);
        drained("t5a_drain");

        // overflow of an unserved FIFO keeps exactly 16 words
        do_reset();
        exp_w(0, 32'h8000_0014);
        for (int k = 1; k <= 20; k++) exp_w(0, 32'h100 + k);
        exp_w(1, 32'h8000_0010);
        for (int k = 1; k <= 15; k++) exp_w(1, 32'h3000 + k);
        exp_w(1, 32'hEE);
        send(2'b11, 32'h8000_0014, 32'h8000_0010);
        for (int k = 1; k <= 15; k++) send(2'b10, 0, 32'h3000 + k);
        chk("t5_no_error_at_16", {31'b0, error}, 32'h0);
        send(2'b10, 0, 32'h3010);
        chk("t5_overflow_error", {31'b0, error}, 32'h1);
        for (int k = 1; k <= 20; k++) send(2'b01, 32'h100 + k, 0);
        idle(20);
        send(2'b10, 0, 32'hEE);
        idle(4);
        drained("t5b_drain");

        // asynchronous reset in the middle of a packet
        do_reset();
        send(2'b01, 32'h7, 0);
        idle(2);
        chk("t6_error_before", {31'b0, error}, 32'h1);
        exp_w(1, 32'h8000_0003); exp_w(1, 32'h41);
        send(2'b10, 0, 32'h8000_0003);
        send(2'b10, 0, 32'h41);
        idle(2);
        drained("t6_pre_drain");
        rst_n = 1'b0;
        #1;
        chk("t6_async_out_data", out_data, 32'h0);
        chk("t6_async_out_nd", {31'b0, out_nd}, 32'h0);
        chk("t6_async_out_stream", {31'b0, out_stream}, 32'h0);
        chk("t6_async_error", {31'b0, error}, 32'h0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        exp_w(1, 32'h8000_0001); exp_w(1, 32'h42);
        send(2'b10, 0, 32'h8000_0001);
        send(2'b10, 0, 32'h42);
        idle(5);
        drained("t6_post_drain");
        chk("t6_error_after", {31'b0, error}, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
